mem_write_checker: RTL and testbench
====================================

// Module: mem_write_checker
// PURPOSE
//  Synthesizable self-checking monitor for the single-cycle MIPS computer's data-memory write port.
//  Holds a table of NCHK expected (address, data) writes and matches every memwrite against it.
//  Flags pass or fail when all entries are hit or when the PC or cycle limit trips.
//  Generalises bench-only write checks to configurable width, entry count and limits.
//  Sits beside dmem: memwrite, dataadr, writedata and pc are tapped from the computer top.
// PARAMETERS
//  N        32   data/address width of dataadr, writedata, pc
//  NCHK     4    expected-write table entries (1..16)
//  CW       16   cycle-counter width
//  PC_LIMIT 100  run ends once pc > PC_LIMIT (unsigned compare)
// PORTS
//  clk        in   1         system clock, rising edge
//  reset      in   1         asynchronous, active-low reset
//  cfg_we     in   1         write table entry cfg_idx (ignored in RUN)
//  cfg_idx    in   $clog2(NCHK) entry index
//  cfg_addr   in   N         expected address
//  cfg_data   in   N         expected data
//  cfg_valid  in   1         entry valid bit written with cfg_we
//  start      in   1         pulse: clear results, enter RUN
//  max_cycles in   CW        cycle budget for the run; 0 = unlimited
//  memwrite   in   1         DUT store strobe
//  dataadr    in   N         DUT store address
//  writedata  in   N         DUT store data
//  pc         in   N         DUT program counter
//  hit_mask   out  NCHK      entry i matched at least once
//  err_count  out  8         mismatching stores, saturates at 255
//  first_err  out  N         address of first mismatching store
//  busy       out  1         state == RUN
//  done       out  1         state is PASS or FAIL (level)
//  pass       out  1         state == PASS
// BEHAVIOUR
//  - Reset: table valid bits = 0, hit_mask = 0, err_count = 0, first_err = 0, cycle counter = 0.
//    State = IDLE, so busy = done = pass = 0. Reset mid-RUN aborts immediately.
//  - FSM states: IDLE, RUN, PASS, FAIL.
//    IDLE -> RUN on start. PASS/FAIL -> RUN on start. start during RUN is ignored.
//  - Entering RUN: hit_mask, err_count, first_err and the cycle counter clear on the start edge.
//    Table contents persist.
//  - Every RUN cycle increments the cycle counter, which saturates at all-ones.
//  - Store evaluation happens in RUN on a clk edge with memwrite = 1:
//    - amatch[i] = valid[i] & (addr[i] == dataadr).
//    - hit[i] = amatch[i] & (data[i] == writedata).
//    - hit_mask |= hit (several entries may hit at once).
//    - If |amatch & ~|hit, the store is a mismatch: err_count++ (saturating).
//      first_err latches dataadr only when err_count was 0.
//  - Ending the run is evaluated on the same edge, after the store update, in priority order:
//    1. all valid entries hit, and at least one valid entry -> PASS if err_count (post-update) == 0, else FAIL.
//    2. pc > PC_LIMIT -> FAIL.
//    3. max_cycles != 0 and counter + 1 >= max_cycles -> FAIL.
//  - A run with no valid entries ends only via limit 2 or 3 and reports FAIL.
//  - Outputs are registered. The result is visible 1 cycle after the deciding store.
//  - cfg_we in IDLE/PASS/FAIL writes the entry next edge; in RUN it is ignored. cfg_idx >= NCHK is ignored.
// CONFIGURATION
//  - WCHK_STRICT_EN defined: a RUN store with no amatch (address not in the table) is also a mismatch.
//    It updates err_count and first_err like any other mismatch.
//  - WCHK_STRICT_EN undefined: stores to unlisted addresses are ignored. Default build leaves it undefined.
// TESTING
//  - Config: entry0 = (1, 0x0C0C000A), entry1 = (63, 0), both valid; start.
//    Drive store (1, 0x0C0C000A), then store (63, 0).
//    Required: hit_mask = 01 then 11; PASS the cycle after the second store; err_count = 0.
//  - Same table; drive store (63, 5), then (1, 0x0C0C000A), then (63, 0).
//    Required: err_count = 1, first_err = 63, hit_mask = 11, final state FAIL.
//  - Same table; only store (1, 0x0C0C000A), then ramp pc to 104.
//    Required: FAIL once pc = 104 is sampled; hit_mask = 01.
//  - max_cycles = 10, no stores. Required: busy for 10 cycles, then done = 1, pass = 0.
//    Also: reset asserted mid-RUN -> all outputs 0 asynchronously.
//  - Build with WCHK_STRICT_EN: store (60, 28) then both expected stores.
//    Required: err_count = 1, first_err = 60, FAIL.
//    Without the macro the same stimulus gives PASS.
//  - 300 mismatching stores -> err_count holds at 255.
//    A start after PASS clears hit_mask and err_count and re-enters RUN.

Source files
------------

// File: rtl/mem_write_checker.sv
// Data-memory write-port monitor: matches stores against an expected table.
// Optional WCHK_STRICT_EN: stores to addresses missing from the table count as mismatches.
module mem_write_checker #(
    parameter int N        = 32,
    parameter int NCHK     = 4,
    parameter int CW       = 16,
    parameter int PC_LIMIT = 100,
    localparam int IW      = (NCHK > 1) ? $clog2(NCHK) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [N-1:0]  cfg_addr,
    input  logic [N-1:0]  cfg_data,
    input  logic          cfg_valid,
    input  logic          start,
    input  logic [CW-1:0] max_cycles,
    input  logic          memwrite,
    input  logic [N-1:0]  dataadr,
    input  logic [N-1:0]  writedata,
    input  logic [N-1:0]  pc,
    output logic [NCHK-1:0] hit_mask,
    output logic [7:0]    err_count,
    output logic [N-1:0]  first_err,
    output logic          busy,
    output logic          done,
    output logic          pass
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    localparam logic [N-1:0] PC_LIM = N'(PC_LIMIT);

    state_t state, state_nxt;

    logic [N-1:0]    tbl_addr [NCHK];
    logic [N-1:0]    tbl_data [NCHK];
    logic [NCHK-1:0] tbl_valid;
    logic [CW-1:0]   cnt;

    logic [NCHK-1:0] amatch, hit, hit_nxt;
    logic            run, store, mism;
    logic            all_hit, pc_trip, cyc_trip;
    logic [7:0]      err_nxt;
    logic [CW:0]     cnt_inc;

    always_comb begin
        amatch = '0;
        hit    = '0;
        for (int i = 0; i < NCHK; i++) begin
            amatch[i] = tbl_valid[i] && (tbl_addr[i] == dataadr);
            hit[i]    = amatch[i] && (tbl_data[i] == writedata);
        end
    end

    assign run   = (state == S_RUN);
    assign store = run && memwrite;

`ifdef WCHK_STRICT_EN
    assign mism = store && !(|hit);
`else
    assign mism = store && (|amatch) && !(|hit);
`endif

    assign hit_nxt = hit_mask | (store ? hit : '0);
    assign err_nxt = (mism && !(&err_count)) ? err_count + 8'd1 : err_count;

    // A run needs at least one valid entry to be able to pass.
    assign all_hit  = (|tbl_valid) && ((hit_nxt & tbl_valid) == tbl_valid);
    assign pc_trip  = pc > PC_LIM;
    assign cnt_inc  = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
    assign cyc_trip = (|max_cycles) && (cnt_inc >= {1'b0, max_cycles});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (all_hit)
                    state_nxt = (err_nxt == 8'd0) ? S_PASS : S_FAIL;
                else if (pc_trip || cyc_trip)
                    state_nxt = S_FAIL;
            end
            default: begin
                if (start) state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tbl_valid <= '0;
            hit_mask  <= '0;
            err_count <= '0;
            first_err <= '0;
            cnt       <= '0;
            for (int i = 0; i < NCHK; i++) begin
                tbl_addr[i] <= '0;
                tbl_data[i] <= '0;
            end
        end else if (!run) begin
            if (cfg_we && (int'(cfg_idx) < NCHK)) begin
                tbl_addr[cfg_idx]  <= cfg_addr;
                tbl_data[cfg_idx]  <= cfg_data;
                tbl_valid[cfg_idx] <= cfg_valid;
            end
            if (start) begin
                hit_mask  <= '0;
                err_count <= '0;
                first_err <= '0;
                cnt       <= '0;
            end
        end else begin
            hit_mask  <= hit_nxt;
            err_count <= err_nxt;
            if (mism && (err_count == 8'd0)) first_err <= dataadr;
            if (!(&cnt)) cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_PASS) || (state == S_FAIL);
    assign pass = (state == S_PASS);

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: directed runs, results checked
// by a monitor whenever done rises.
module tb_mem_write_checker;

    localparam int N  = 32;
    localparam int NC = 4;
    localparam int CW = 16;
    localparam logic [31:0] A1 = 32'h0C0C000A;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [1:0]    cfg_idx;
    logic [N-1:0]  cfg_addr, cfg_data;
    logic          cfg_valid;
    logic          start;
    logic [CW-1:0] max_cycles;
    logic          memwrite;
    logic [N-1:0]  dataadr, writedata, pc;
    logic [NC-1:0] hit_mask;
    logic [7:0]    err_count;
    logic [N-1:0]  first_err;
    logic          busy, done, pass;

    typedef struct packed {
        logic        pass;
        logic [7:0]  err;
        logic [31:0] first;
        logic [3:0]  hit;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic done_q = 1'b0;

    mem_write_checker #(.N(N), .NCHK(NC), .CW(CW), .PC_LIMIT(100)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_valid(cfg_valid), .start(start),
        .max_cycles(max_cycles), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .pc(pc),
        .hit_mask(hit_mask), .err_count(err_count),
        .first_err(first_err), .busy(busy),
        .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one expected result per completed run.
    always @(negedge clk) begin
        if (reset && done && !done_q) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res_pass", {31'd0, pass}, {31'd0, e.pass});
                chk("res_err", {24'd0, err_count}, {24'd0, e.err});
                chk("res_first", first_err, e.first);
                chk("res_hit", {28'd0, hit_mask}, {28'd0, e.hit});
            end
        end
        done_q = done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] i, input logic [31:0] a,
                       input logic [31:0] d, input logic v);
        cfg_we = 1'b1; cfg_idx = i;
        cfg_addr = a; cfg_data = d; cfg_valid = v;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        step();
        memwrite = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 50) begin
            step();
            n++;
        end
        chk(name, {31'd0, done}, 32'd1);
        step();
    endtask

    task automatic setup_tbl();
        cfg(2'd0, 32'd1, A1, 1'b1);
        cfg(2'd1, 32'd63, 32'd0, 1'b1);
    endtask

    initial begin
        int n;
        reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_addr = '0; cfg_data = '0; cfg_valid = 1'b0;
        start = 1'b0; max_cycles = '0; memwrite = 1'b0;
        dataadr = '0; writedata = '0; pc = '0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_hit", {28'd0, hit_mask}, 32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        reset = 1'b1;
        step();
        setup_tbl();

        // Run 1: both stores match -> PASS; cfg writes in RUN are dropped.
        go();
        chk("r1_busy", {31'd0, busy}, 32'd1);
        q.push_back('{1'b1, 8'd0, 32'd0, 4'b0011});
        st(32'd1, A1);
        chk("r1_hit01", {28'd0, hit_mask}, 32'h1);
        cfg(2'd2, 32'd200, 32'd7, 1'b1);
        st(32'd63, 32'd0);
        chk("r1_pass_now", {31'd0, pass}, 32'd1);
        wait_done("r1_done");

        // Restart clears results.
        go();
        chk("rs_hit", {28'd0, hit_mask}, 32'd0);
        chk("rs_err", {24'd0, err_count}, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd1);

        // Run 2: wrong data first -> FAIL with first_err = 63.
        q.push_back('{1'b0, 8'd1, 32'd63, 4'b0011});
        st(32'd63, 32'd5);
        chk("r2_err1", {24'd0, err_count}, 32'd1);
        chk("r2_first", first_err, 32'd63);
        st(32'd1, A1);
        st(32'd63, 32'd0);
        wait_done("r2_done");

        // Run 3: pc limit.
        go();
        q.push_back('{1'b0, 8'd0, 32'd0, 4'b0001});
        st(32'd1, A1);
        for (int p = 0; p <= 100; p += 4) begin
            pc = p;
            step();
            if (p == 100) chk("r3_busy_at100", {31'd0, busy}, 32'd1);
        end
        pc = 32'd104;
        step();
        chk("r3_fail_now", {31'd0, done & ~pass}, 32'd1);
        pc = '0;
        wait_done("r3_done");

        // Run 4: cycle budget of 10.
        max_cycles = 16'd10;
        go();
        q.push_back('{1'b0, 8'd0, 32'd0, 4'b0000});
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk("r4_busy_cycles", n, 32'd10);
        chk("r4_pass", {31'd0, pass}, 32'd0);
        max_cycles = '0;
        wait_done("r4_done");

        // Asynchronous reset mid-RUN.
        go();
        st(32'd63, 32'd5);
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_done", {31'd0, done}, 32'd0);
        chk("ab_err", {24'd0, err_count}, 32'd0);
        chk("ab_first", first_err, 32'd0);
        step();
        reset = 1'b1;
        step();
        setup_tbl();

        // Run 5: store to an unlisted address.
        go();
`ifdef WCHK_STRICT_EN
        q.push_back('{1'b0, 8'd1, 32'd60, 4'b0011});
`else
        q.push_back('{1'b1, 8'd0, 32'd0, 4'b0011});
`endif
        st(32'd60, 32'd28);
        st(32'd1, A1);
        st(32'd63, 32'd0);
        wait_done("r5_done");

        // Run 6: error counter saturation.
        go();
        q.push_back('{1'b0, 8'd255, 32'd63, 4'b0011});
        for (int k = 0; k < 300; k++) st(32'd63, 32'd5);
        chk("r6_sat", {24'd0, err_count}, 32'd255);
        chk("r6_busy", {31'd0, busy}, 32'd1);
        st(32'd1, A1);
        st(32'd63, 32'd0);
        wait_done("r6_done");

        step();
        step();
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
